// File: rtl/muldiv_issue_pkg.sv
// Shared types for the EX-stage multiply/divide issue logic.
// FSM states, funct3 encodings and datapath widths.
package muldiv_issue_pkg;

   localparam int XLEN = 32;
   localparam int RD_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } md_state_e;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/muldiv_issue_if.sv
// EX / muldiv-unit / WB signal bundle around the issue block.
// master = issue block side, slave = environment side.
interface muldiv_issue_if;
   import muldiv_issue_pkg::*;

   logic            ex_valid;
   logic            ex_is_muldiv;
   logic [2:0]      ex_op;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;
   logic [RD_W-1:0] ex_rd;
   logic            ex_flush;
   logic            ex_stall;

   logic            md_op_valid;
   logic [2:0]      md_op;
   logic [XLEN-1:0] md_op1;
   logic [XLEN-1:0] md_op2;
   logic            md_op_stall;
   logic            md_op_ready;
   logic [XLEN-1:0] md_op_out;

   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            wb_ready;

   logic            perf_busy;

   modport master (
      input  ex_valid, ex_is_muldiv, ex_op,
      input  ex_rs1_val, ex_rs2_val, ex_rd,
      input  ex_flush,
      output ex_stall,
      output md_op_valid, md_op, md_op1, md_op2,
      output md_op_stall,
      input  md_op_ready, md_op_out,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready,
      output perf_busy
   );

   modport slave (
      output ex_valid, ex_is_muldiv, ex_op,
      output ex_rs1_val, ex_rs2_val, ex_rd,
      output ex_flush,
      input  ex_stall,
      input  md_op_valid, md_op, md_op1, md_op2,
      input  md_op_stall,
      output md_op_ready, md_op_out,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready,
      input  perf_busy
   );

endinterface

// File: rtl/muldiv_issue.sv
// Issues M-extension ops to the muldiv unit, stalls EX meanwhile,
// and parks the result in a one-entry WB buffer.
module muldiv_issue
   import muldiv_issue_pkg::*;
(
   input  logic           clk,
   input  logic           rstn,
   muldiv_issue_if.master bus
);

   md_state_e       state_q, state_d;
   logic            busy_q;
   logic [2:0]      op_q;
   logic [XLEN-1:0] op1_q, op2_q;
   logic [RD_W-1:0] rd_q;
   logic            wb_valid_q;
   logic [RD_W-1:0] wb_rd_q;
   logic [XLEN-1:0] wb_data_q;

   logic accept, stall, done, load;

   always_comb begin
      accept  = (state_q == ST_IDLE) & bus.ex_valid
              & bus.ex_is_muldiv & ~bus.ex_flush;
      // A draining op is thrown away, so it never needs backpressure.
      stall   = (state_q != ST_DRAIN) & wb_valid_q & ~bus.wb_ready;
      done    = (state_q == ST_ISSUE) & bus.md_op_ready & ~stall;
      load    = done & ~bus.ex_flush;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (done)              state_d = ST_IDLE;
            else if (bus.ex_flush) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (bus.md_op_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         op_q       <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
         // md_op_out is combinational on md_op: operands only move on accept.
         if (accept) begin
            op_q  <= bus.ex_op;
            op1_q <= bus.ex_rs1_val;
            op2_q <= bus.ex_rs2_val;
            rd_q  <= bus.ex_rd;
         end
         if (load) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= bus.md_op_out;
         end else if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
         end
      end
   end

   assign bus.ex_stall    = bus.ex_valid & bus.ex_is_muldiv
                          & ~bus.ex_flush & ~done;
   assign bus.md_op_valid = busy_q;
   assign bus.md_op       = op_q;
   assign bus.md_op1      = op1_q;
   assign bus.md_op2      = op2_q;
   assign bus.md_op_stall = stall;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.perf_busy   = busy_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue with a 64-cycle behavioural muldiv unit.
// Expected results come from RISC-V M-extension arithmetic.
module tb_muldiv_issue;
   import muldiv_issue_pkg::*;

   logic clk;
   logic rstn;
   int   total = 0;
   int   bad   = 0;

   muldiv_issue_if bus ();

   muldiv_issue u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_md(
      input logic [2:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (op)
         F3_MUL:    begin p = ua * ub; return p[31:0]; end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
         F3_MULHU:  begin p = ua * ub; return p[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         F3_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Behavioural muldiv unit: starts when it sees a request while idle,
   // raises ready 64 cycles later and holds it while stalled.
   logic unit_busy;
   int   unit_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         unit_busy <= 1'b0;
         unit_cnt  <= 0;
      end else if (!unit_busy) begin
         if (bus.md_op_valid) begin
            unit_busy <= 1'b1;
            unit_cnt  <= 1;
         end
      end else if (bus.md_op_ready && !bus.md_op_stall) begin
         unit_busy <= 1'b0;
      end else if (unit_cnt < 64) begin
         unit_cnt <= unit_cnt + 1;
      end
   end

   assign bus.md_op_ready = unit_busy && (unit_cnt == 64);
   assign bus.md_op_out   = ref_md(bus.md_op, bus.md_op1, bus.md_op2);

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      bus.ex_valid     = 1'b1;
      bus.ex_is_muldiv = 1'b1;
      bus.ex_op        = op;
      bus.ex_rs1_val   = a;
      bus.ex_rs2_val   = b;
      bus.ex_rd        = rd;
   endtask

   task automatic idle_ex();
      bus.ex_valid     = 1'b0;
      bus.ex_is_muldiv = 1'b0;
   endtask

   // Present an op, hold it while stalled, then check the WB buffer.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input bit held,
                         output int rdy_n, output bit early_wb);
      drive(op, a, b, rd);
      rdy_n    = -1;
      early_wb = 1'b0;
      #1;
      chk("stall_accept", bus.ex_stall, 1);
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            chk("op_valid_t1", bus.md_op_valid, 1);
            if (!held) begin
               chk("op_hold", {bus.md_op, bus.md_op1}, {op, a});
               chk("op2_hold", bus.md_op2, b);
            end
         end
         if (bus.wb_valid) early_wb = 1'b1;
         if (!bus.ex_stall) begin
            rdy_n = n;
            break;
         end
      end
      idle_ex();
      if (rdy_n < 0) begin
         chk("timeout", 0, 1);
      end else begin
         chk("ready_at_release", bus.md_op_ready, 1);
         @(posedge clk);
         #1;
         chk("wb_valid", bus.wb_valid, 1);
         chk("wb_data", bus.wb_data, exp);
         chk("wb_rd", bus.wb_rd, rd);
      end
   endtask

   initial begin
      int  rn;
      bit  ew;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      logic [4:0]  rrd;

      rstn             = 1'b0;
      bus.ex_valid     = 1'b0;
      bus.ex_is_muldiv = 1'b0;
      bus.ex_op        = '0;
      bus.ex_rs1_val   = '0;
      bus.ex_rs2_val   = '0;
      bus.ex_rd        = '0;
      bus.ex_flush     = 1'b0;
      bus.wb_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_op_valid", bus.md_op_valid, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_ex_stall", bus.ex_stall, 0);
      chk("rst_op_stall", bus.md_op_stall, 0);
      chk("rst_busy", bus.perf_busy, 0);
      chk("rst_ops", {bus.md_op, bus.md_op1, bus.md_op2}, 0);
      chk("rst_wb", {bus.wb_rd, bus.wb_data}, 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      run_op(F3_MUL, 7, 6, 5'd9, 32'h2A, 0, rn, ew);
      chk("mul_latency", rn, 65);
      chk("mul_no_early_wb", ew, 0);

      run_op(F3_MULH, '1, '1, 5'd1, 32'h0, 0, rn, ew);
      run_op(F3_MULHU, '1, '1, 5'd2, 32'hFFFF_FFFE, 0, rn, ew);
      run_op(F3_DIV, 100, 0, 5'd3, 32'hFFFF_FFFF, 0, rn, ew);
      run_op(F3_REM, 100, 0, 5'd4, 32'd100, 0, rn, ew);
      run_op(F3_DIV, 32'h8000_0000, '1, 5'd5, 32'h8000_0000, 0, rn, ew);

      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         rrd = 5'($urandom);
         run_op(rop, ra, rb, rrd, ref_md(rop, ra, rb), 0, rn, ew);
         chk("rand_latency", rn, 65);
      end

      // Flush 10 cycles in: op drains, result discarded, next op waits.
      drive(F3_MUL, 9, 9, 5'd7);
      repeat (10) @(posedge clk);
      #1;
      idle_ex();
      bus.ex_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.ex_flush = 1'b0;
      chk("drain_busy", bus.perf_busy, 1);
      chk("drain_op_valid", bus.md_op_valid, 1);
      chk("drain_flush_stall", bus.md_op_stall, 0);
      run_op(F3_MUL, 3, 5, 5'd8, 32'd15, 1, rn, ew);
      chk("drain_no_wb", ew, 0);
      chk("drain_held", rn > 65, 1);

      // Flush coinciding with ready discards the result.
      drive(F3_MUL, 2, 3, 5'd6);
      repeat (65) @(posedge clk);
      #1;
      chk("coinc_ready", bus.md_op_ready, 1);
      idle_ex();
      bus.ex_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.ex_flush = 1'b0;
      chk("coinc_no_wb", bus.wb_valid, 0);
      chk("coinc_idle", bus.perf_busy, 0);

      // WB backpressure holds the completing op.
      bus.wb_ready = 1'b0;
      run_op(F3_MUL, 11, 11, 5'd10, 32'd121, 0, rn, ew);
      drive(F3_MUL, 4, 5, 5'd11);
      repeat (66) @(posedge clk);
      #1;
      chk("bp_op_stall", bus.md_op_stall, 1);
      chk("bp_ready_held", bus.md_op_ready, 1);
      chk("bp_ex_stall", bus.ex_stall, 1);
      chk("bp_old_data", bus.wb_data, 32'd121);
      chk("bp_old_rd", bus.wb_rd, 5'd10);
      bus.wb_ready = 1'b1;
      #1;
      chk("bp_release", bus.ex_stall, 0);
      idle_ex();
      @(posedge clk);
      #1;
      chk("bp_wb_valid", bus.wb_valid, 1);
      chk("bp_new_data", bus.wb_data, 32'd20);
      chk("bp_new_rd", bus.wb_rd, 5'd11);

      // Asynchronous reset in the middle of a divide.
      drive(F3_DIV, 100, 7, 5'd12);
      repeat (20) @(posedge clk);
      #1;
      idle_ex();
      rstn = 1'b0;
      #1;
      chk("mrst_busy", bus.perf_busy, 0);
      chk("mrst_op_valid", bus.md_op_valid, 0);
      chk("mrst_ops", {bus.md_op, bus.md_op1, bus.md_op2}, 0);
      chk("mrst_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data}, 0);
      chk("mrst_stalls", {bus.ex_stall, bus.md_op_stall}, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      run_op(F3_MUL, 2, 2, 5'd13, 32'd4, 0, rn, ew);
      chk("post_rst_latency", rn, 65);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
